// File: rtl/fpnew_opgroup_out_arbiter_pkg.sv
// Shared types and helpers for the opgroup output arbiter.
// status_t mirrors the IEEE exception flag layout, with nx as the LSB.
package fpnew_opgroup_out_arbiter_pkg;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fpnew_opgroup_out_arbiter_rr_pick.sv
// Combinational cyclic priority picker: first request at or above start_i, else wraps to the lowest.
// Produces a one-hot grant plus its encoded index; all zero when nothing requests.
module fpnew_opgroup_out_arbiter_rr_pick
    import fpnew_opgroup_out_arbiter_pkg::*;
#(
    parameter int unsigned NumReq   = 4,
    parameter int unsigned IdxWidth = idx_width(NumReq)
) (
    input  logic [NumReq-1:0]   req_i,
    input  logic [IdxWidth-1:0] start_i,
    output logic [NumReq-1:0]   gnt_o,
    output logic [IdxWidth-1:0] idx_o,
    output logic                any_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        // Upper segment [start, NumReq) has priority over the wrapped segment [0, start).
        for (int unsigned j = 0; j < NumReq; j++) begin
            if (!found && req_i[j] && (j >= 32'(start_i))) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IdxWidth'(j);
            end
        end
        for (int unsigned j = 0; j < NumReq; j++) begin
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IdxWidth'(j);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/fpnew_opgroup_out_arbiter.sv
// Round-robin arbiter sharing one opgroup output register between format slices.
// The holding register reloads whenever it is empty or being drained, giving 1 result/cycle.
module fpnew_opgroup_out_arbiter
    import fpnew_opgroup_out_arbiter_pkg::*;
#(
    parameter int unsigned  NumSlices = 4,
    parameter int unsigned  Width     = 64,
    parameter type          TagType   = logic,
    localparam int unsigned IdxWidth  = idx_width(NumSlices)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumSlices-1:0][Width-1:0]     slice_result_i,
    input  status_t [NumSlices-1:0]             slice_status_i,
    input  logic [NumSlices-1:0]                slice_ext_bit_i,
    input  TagType [NumSlices-1:0]              slice_tag_i,
    input  logic [NumSlices-1:0]                slice_valid_i,
    output logic [NumSlices-1:0]                slice_ready_o,
    input  logic                                flush_i,
    output logic [Width-1:0]                    result_o,
    output status_t                             status_o,
    output logic                                extension_bit_o,
    output TagType                              tag_o,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [IdxWidth-1:0]                 grant_idx_o,
    output logic                                busy_o
);

    logic [NumSlices-1:0] pick_gnt;
    logic [IdxWidth-1:0]  pick_idx;
    logic                 pick_any;
    logic                 load_en;
    logic                 grant;
    logic [IdxWidth-1:0]  rr_d;

    logic [Width-1:0]     sel_result;
    status_t              sel_status;
    logic                 sel_ext;
    TagType               sel_tag;

    logic                 out_valid_q;
    logic [Width-1:0]     result_q;
    status_t              status_q;
    logic                 ext_q;
    TagType               tag_q;
    logic [IdxWidth-1:0]  idx_q;
    logic [IdxWidth-1:0]  rr_q;

    fpnew_opgroup_out_arbiter_rr_pick #(
        .NumReq   (NumSlices),
        .IdxWidth (IdxWidth)
    ) u_rr_pick (
        .req_i   (slice_valid_i),
        .start_i (rr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign load_en       = (~out_valid_q | out_ready_i) & ~flush_i;
    assign grant         = load_en & pick_any;
    assign slice_ready_o = load_en ? pick_gnt : '0;
    assign rr_d          = (32'(pick_idx) == NumSlices - 1) ? '0 : pick_idx + 1'b1;

    // One-hot select keeps the mux free of out-of-range indexing for non power-of-two counts.
    always_comb begin
        sel_result = '0;
        sel_status = '0;
        sel_ext    = 1'b0;
        sel_tag    = '0;
        for (int unsigned i = 0; i < NumSlices; i++) begin
            if (pick_gnt[i]) begin
                sel_result = slice_result_i[i];
                sel_status = slice_status_i[i];
                sel_ext    = slice_ext_bit_i[i];
                sel_tag    = slice_tag_i[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            status_q    <= '0;
            ext_q       <= 1'b0;
            tag_q       <= '0;
            idx_q       <= '0;
            rr_q        <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (grant) begin
            out_valid_q <= 1'b1;
            result_q    <= sel_result;
            status_q    <= sel_status;
            ext_q       <= sel_ext;
            tag_q       <= sel_tag;
            idx_q       <= pick_idx;
            rr_q        <= rr_d;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign result_o        = result_q;
    assign status_o        = status_q;
    assign extension_bit_o = ext_q;
    assign tag_o           = tag_q;
    assign out_valid_o     = out_valid_q;
    assign grant_idx_o     = idx_q;
    assign busy_o          = out_valid_q | (|slice_valid_i);

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(slice_ready_o));

    a_ready_needs_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (slice_ready_o & ~slice_valid_i) == '0);

    a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i && !flush_i) |=>
        (out_valid_o && $stable(result_o) && $stable(tag_o) && $stable(grant_idx_o)));

endmodule

// File: tb/tb_fpnew_opgroup_out_arbiter.sv
// Directed bench for the opgroup output arbiter: 4-slice instance checked every cycle against a
// modulo-arithmetic model, plus a 1-slice instance checked with a tag scoreboard.
module tb_fpnew_opgroup_out_arbiter;
    import fpnew_opgroup_out_arbiter_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned W = 64;
    typedef logic [3:0] tag4_t;
    typedef logic [7:0] tag8_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks;
    int failures;
    logic chk_en;

    // 4-slice DUT signals
    logic [N-1:0][W-1:0] s_res;
    status_t [N-1:0]     s_st;
    logic [N-1:0]        s_ext;
    tag4_t [N-1:0]       s_tag;
    logic [N-1:0]        s_valid;
    logic [N-1:0]        s_ready;
    logic                flush;
    logic                out_ready;
    logic [W-1:0]        o_res;
    status_t             o_st;
    logic                o_ext;
    tag4_t               o_tag;
    logic                o_valid;
    logic [1:0]          o_idx;
    logic                o_busy;

    // 1-slice DUT signals
    logic [0:0][W-1:0]   u_res;
    status_t [0:0]       u_st;
    logic [0:0]          u_ext;
    tag8_t [0:0]         u_tag;
    logic [0:0]          u_valid;
    logic [0:0]          u_ready;
    logic                u_flush;
    logic                u_out_ready;
    logic [W-1:0]        u_o_res;
    status_t             u_o_st;
    logic                u_o_ext;
    tag8_t               u_o_tag;
    logic                u_o_valid;
    logic [0:0]          u_o_idx;
    logic                u_busy;

    fpnew_opgroup_out_arbiter #(
        .NumSlices (N),
        .Width     (W),
        .TagType   (tag4_t)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .slice_result_i  (s_res),
        .slice_status_i  (s_st),
        .slice_ext_bit_i (s_ext),
        .slice_tag_i     (s_tag),
        .slice_valid_i   (s_valid),
        .slice_ready_o   (s_ready),
        .flush_i         (flush),
        .result_o        (o_res),
        .status_o        (o_st),
        .extension_bit_o (o_ext),
        .tag_o           (o_tag),
        .out_valid_o     (o_valid),
        .out_ready_i     (out_ready),
        .grant_idx_o     (o_idx),
        .busy_o          (o_busy)
    );

    fpnew_opgroup_out_arbiter #(
        .NumSlices (1),
        .Width     (W),
        .TagType   (tag8_t)
    ) dut1 (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .slice_result_i  (u_res),
        .slice_status_i  (u_st),
        .slice_ext_bit_i (u_ext),
        .slice_tag_i     (u_tag),
        .slice_valid_i   (u_valid),
        .slice_ready_o   (u_ready),
        .flush_i         (u_flush),
        .result_o        (u_o_res),
        .status_o        (u_o_st),
        .extension_bit_o (u_o_ext),
        .tag_o           (u_o_tag),
        .out_valid_o     (u_o_valid),
        .out_ready_i     (u_out_ready),
        .grant_idx_o     (u_o_idx),
        .busy_o          (u_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model: first valid slice scanning cyclically from the pointer, computed with modulo arithmetic.
    function automatic int first_valid(input logic [3:0] v, input int rr);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (rr + k) % 4;
            if (v[j[1:0]]) return j;
        end
        return -1;
    endfunction

    int         m_rr;
    int         m_idx;
    int         m_win;
    logic       m_load;
    logic [3:0] m_rdy;
    logic       m_valid;
    logic [63:0] m_res;
    status_t    m_st;
    logic       m_ext;
    tag4_t      m_tag;

    always_comb begin
        m_load = !flush && (!m_valid || out_ready);
        m_win  = first_valid(s_valid, m_rr);
        m_rdy  = '0;
        if (m_load && m_win >= 0) m_rdy[m_win[1:0]] = 1'b1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_res   <= '0;
            m_st    <= '0;
            m_ext   <= 1'b0;
            m_tag   <= '0;
            m_idx   <= 0;
            m_rr    <= 0;
        end else begin
            // Occupied next cycle if something was taken in, or the held item was not taken out.
            m_valid <= !flush && ((m_rdy != 4'b0) || (m_valid && !out_ready));
            if (m_rdy != 4'b0) begin
                m_res <= s_res[m_win[1:0]];
                m_st  <= s_st[m_win[1:0]];
                m_ext <= s_ext[m_win[1:0]];
                m_tag <= s_tag[m_win[1:0]];
                m_idx <= m_win;
                m_rr  <= (m_win + 1) % 4;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_ready", 64'(s_ready), 64'(m_rdy));
            chk("m_out_valid", 64'(o_valid), 64'(m_valid));
            chk("m_result", o_res, m_res);
            chk("m_status", 64'(o_st), 64'(m_st));
            chk("m_ext", 64'(o_ext), 64'(m_ext));
            chk("m_tag", 64'(o_tag), 64'(m_tag));
            chk("m_grant_idx", 64'(o_idx), 64'(m_idx[1:0]));
            chk("m_busy", 64'(o_busy), 64'(m_valid | (|s_valid)));
        end
    end

    int src;
    int outc;
    int held;
    logic take_in;
    logic take_out;

    initial begin
        checks = 0;
        failures = 0;
        chk_en = 1'b0;
        s_valid = '0;
        flush = 1'b0;
        out_ready = 1'b0;
        u_valid = '0;
        u_flush = 1'b0;
        u_out_ready = 1'b0;
        u_res = '0;
        u_st = '0;
        u_ext = '0;
        u_tag = '0;
        for (int i = 0; i < 4; i++) begin
            s_res[i] = 64'h0123_4567_89AB_0000 + 64'(i);
            s_tag[i] = 4'(i + 8);
            s_st[i]  = status_t'(5'(1 << i));
            s_ext[i] = i[0];
        end
        s_res[2] = 64'h3FF0_0000_0000_0000;
        s_tag[2] = 4'd5;
        s_st[2]  = status_t'(5'b00001);

        // Reset
        #2 rst_n = 1'b0;
        #20;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_result", o_res, 64'd0);
        chk("rst_status", 64'(o_st), 64'd0);
        chk("rst_ext", 64'(o_ext), 64'd0);
        chk("rst_tag", 64'(o_tag), 64'd0);
        chk("rst_idx", 64'(o_idx), 64'd0);
        chk("rst_u_valid", 64'(u_o_valid), 64'd0);
        cyc();
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Single request from slice 2
        s_valid = 4'b0100;
        out_ready = 1'b1;
        #2 chk("t1_ready", 64'(s_ready), 64'b0100);
        cyc();
        s_valid = 4'b0000;
        chk("t1_valid", 64'(o_valid), 64'd1);
        chk("t1_result", o_res, 64'h3FF0_0000_0000_0000);
        chk("t1_tag", 64'(o_tag), 64'd5);
        chk("t1_idx", 64'(o_idx), 64'd2);
        chk("t1_nx", 64'(o_st.nx), 64'd1);
        // Pointer now at 3: with slices 0 and 3 requesting, 3 wins
        s_valid = 4'b1001;
        #2 chk("t1_rr3", 64'(s_ready), 64'b1000);
        cyc();
        s_valid = 4'b0000;
        chk("t1_idx3", 64'(o_idx), 64'd3);

        // All slices streaming from pointer 0
        s_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #2 chk("t2_ready", 64'(s_ready), 64'(4'b0001 << (k % 4)));
            cyc();
            chk("t2_valid", 64'(o_valid), 64'd1);
            chk("t2_idx", 64'(o_idx), 64'(k % 4));
        end

        // Backpressure while holding slice 1
        s_valid = 4'b0010;
        #2 chk("t3_ready1", 64'(s_ready), 64'b0010);
        cyc();
        out_ready = 1'b0;
        s_valid = 4'b1001;
        chk("t3_idx1", 64'(o_idx), 64'd1);
        for (int k = 0; k < 3; k++) begin
            #2 chk("t3_stall_ready", 64'(s_ready), 64'd0);
            cyc();
            chk("t3_hold_idx", 64'(o_idx), 64'd1);
            chk("t3_hold_res", o_res, 64'h0123_4567_89AB_0001);
            chk("t3_hold_valid", 64'(o_valid), 64'd1);
        end
        out_ready = 1'b1;
        #2 chk("t3_release", 64'(s_ready), 64'b1000);
        cyc();
        chk("t3_idx3", 64'(o_idx), 64'd3);

        // Flush with slice 0 requesting
        s_valid = 4'b0001;
        flush = 1'b1;
        out_ready = 1'b0;
        #2 chk("t4_flush_ready", 64'(s_ready), 64'd0);
        cyc();
        flush = 1'b0;
        out_ready = 1'b1;
        chk("t4_flushed", 64'(o_valid), 64'd0);
        #2 chk("t4_ready0", 64'(s_ready), 64'b0001);
        cyc();
        chk("t4_idx0", 64'(o_idx), 64'd0);
        chk("t4_valid", 64'(o_valid), 64'd1);

        // Asynchronous reset mid-stream
        s_valid = 4'b1111;
        cyc();
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", 64'(o_valid), 64'd0);
        chk("t5_idx", 64'(o_idx), 64'd0);
        chk("t5_res", o_res, 64'd0);
        chk("t5_tag", 64'(o_tag), 64'd0);
        cyc();
        rst_n = 1'b1;
        #2 chk("t5_restart", 64'(s_ready), 64'b0001);
        cyc();
        chk("t5_idx0", 64'(o_idx), 64'd0);
        s_valid = 4'b0000;
        out_ready = 1'b0;

        // Single-slice pipeline register, tag scoreboard
        src = 1;
        outc = 1;
        u_valid = 1'b1;
        for (int k = 0; k < 15; k++) begin
            u_out_ready = ((k % 3) != 1);
            u_tag[0] = 8'(src);
            u_res[0] = 64'(src);
            held = src - outc;
            take_in = (held == 0) || u_out_ready;
            take_out = (held != 0) && u_out_ready;
            #2;
            chk("t6_ready", 64'(u_ready), 64'(take_in));
            chk("t6_valid", 64'(u_o_valid), 64'(held != 0));
            if (held != 0) begin
                chk("t6_tag", 64'(u_o_tag), 64'(outc));
                chk("t6_res", u_o_res, 64'(outc));
            end
            cyc();
            if (take_in) src++;
            if (take_out) outc++;
        end
        u_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpnew_opgroup_out_arbiter.md
Name: fpnew_opgroup_out_arbiter

Overview:
Shares one opgroup output port between the format slices of an opgroup block. Each slice offers a completed result with its status, extension bit and tag. The arbiter picks one valid slice per cycle, round-robin, and captures it in a single output holding register. That register drives the opgroup's downstream valid/ready handshake toward the FPU top-level output arbiter.

Parameters:
NumSlices, 4, number of format slices requesting the output (>=1; 1 degenerates to a pass-through register)
Width, 64, result width in bits
TagType, logic, type of the operation tag carried with each result
IdxWidth, derived (localparam), max(1, $clog2(NumSlices))

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
slice_result_i  in  NumSlices x Width  per-slice result
slice_status_i  in  NumSlices x fpnew_pkg::status_t  per-slice IEEE flags
slice_ext_bit_i  in  NumSlices  per-slice extension (NaN-box/sign) bit
slice_tag_i  in  NumSlices x TagType  per-slice tag
slice_valid_i  in  NumSlices  per-slice result valid
slice_ready_o  out  NumSlices  per-slice accept; at most one bit high per cycle
flush_i  in  1  synchronous flush of held result
result_o  out  Width  held result
status_o  out  fpnew_pkg::status_t  held status
extension_bit_o  out  1  held extension bit
tag_o  out  TagType  held tag
out_valid_o  out  1  held result valid
out_ready_i  in  1  downstream accept
grant_idx_o  out  IdxWidth  index of slice whose result is currently held (debug/perf)
busy_o  out  1  data held or any slice requesting

Behaviour:
- Reset (async, rst_ni=0). The following registers are 0: out_valid_o, result_o, status_o, extension_bit_o, tag_o ('0), grant_idx_o, and the round-robin pointer rr_q.
- Holding register may load in a cycle (load_en) when: ~out_valid_o | out_ready_i, and flush_i=0.
- Arbitration (combinational):
  - Winner g is the first index with slice_valid_i set, scanning cyclically from rr_q upward: rr_q, rr_q+1, …, wrapping modulo NumSlices.
  - slice_ready_o[g] = load_en & (|slice_valid_i). All other bits of slice_ready_o are 0.
  - No slice_ready_o bit is ever high without a corresponding valid; the handshake completes only when valid and ready are both high.
- On a grant (posedge):
  - result/status/ext/tag register <= slice g's values; grant_idx_o <= g; out_valid_o <= 1.
  - rr_q <= (g == NumSlices-1) ? 0 : g+1.
- Drain without reload: out_valid_o & out_ready_i with no requester → out_valid_o <= 0. Data registers keep their old values.
- Simultaneous drain and load: allowed. Sustained throughput is 1 result/cycle; latency from slice handshake to out_valid_o is 1 cycle.
- Backpressure: out_valid_o=1 and out_ready_i=0 → all slice_ready_o=0. Held data and rr_q are frozen, and held outputs stay stable until accepted.
- Flush:
  - flush_i=1 → out_valid_o <= 0 next cycle and all slice_ready_o=0 that cycle.
  - rr_q is unchanged. Slices perform their own flush.
- Fairness: a continuously requesting slice is granted within NumSlices grants.
- busy_o = out_valid_o | (|slice_valid_i).
- Status is passed through unmodified; lane collapsing is done inside each slice.

Decomposition:
- No new fpnew_pkg types needed; uses fpnew_pkg::status_t. IdxWidth is a local localparam.
- One natural sub-module: fpnew_rr_pick, a combinational cyclic priority picker (req vector, start pointer → one-hot grant + index). It is reusable by the top-level opgroup arbiter.

Test Plan:
1. Reset, then NumSlices=4. Slice 2 valid with result 0x3FF0_0000_0000_0000, tag 5, status NX, out_ready_i=1.
   → slice_ready_o=4'b0100 in cycle 0. Next cycle out_valid_o=1, result_o matches, tag_o=5, grant_idx_o=2, status_o.NX=1. rr_q=3.
2. All four slices valid continuously, out_ready_i=1, rr_q=0.
   → grants in order 0,1,2,3,0, one per cycle. out_valid_o stays 1 with no bubbles.
3. Slice 1 held, out_ready_i=0 for 3 cycles while slices 0 and 3 are valid.
   → slice_ready_o=0 for those cycles; result_o and grant_idx_o unchanged. When out_ready_i rises, the same cycle grants slice 3 (rr_q=2 → next valid at/after 2 is 3).
4. out_valid_o=1, flush_i=1 with slice 0 valid.
   → slice_ready_o=0 that cycle. Next cycle out_valid_o=0 and rr_q unchanged; the following cycle grants slice 0.
5. rst_ni asserted mid-stream with out_valid_o=1.
   → out_valid_o, grant_idx_o and data go to 0 immediately (asynchronous). After release, arbitration restarts at slice 0.
6. NumSlices=1, a single slice streaming with out_ready_i toggling 1,0,1.
   → behaves as a 1-entry pipeline register. No result is lost or duplicated (scoreboard on tag).
